// File: rtl/pll_reg_bank_if.sv
// Control-bus interface for the PLL register bank: address/data, single-cycle
// read and write strobes, and the registered read response with error flag.
interface pll_reg_bank_if #(
    parameter int AW = 8
);
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          wen;
    logic          ren;
    logic [7:0]    rdata;
    logic          rvalid;
    logic          err;

    modport master (output addr, wdata, wen, ren, input rdata, rvalid, err);
    modport slave  (input addr, wdata, wen, ren, output rdata, rvalid, err);
endinterface

// File: rtl/pll_reg_bank.sv
// PLL configuration/status register bank.
// DIV/VCO/LPF are double-buffered (shadow -> active on COMMIT), STATUS holds a
// synchronised lock flag and a sticky W1C lock_lost bit, plus NSCRATCH scratch
// registers at 0x05 upward. Optional macro PLL_REG_SAFE_COMMIT_EN rejects a
// COMMIT while the PLL is enabled.
module pll_reg_bank #(
    parameter int         AW       = 8,
    parameter int         NSCRATCH = 2,
    parameter logic [7:0] DIV_RST  = 8'h00,
    parameter logic [3:0] VCO_RST  = 4'h0,
    parameter logic [5:0] LPF_RST  = 6'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    pll_reg_bank_if.slave       bus,
    input  logic                pll_locked,
    output logic [7:0]          div_cfg,
    output logic [3:0]          vco_gain,
    output logic [1:0]          lpf_c2,
    output logic [1:0]          lpf_cp,
    output logic [1:0]          lpf_rp,
    output logic                enable_pll,
    output logic                commit_o
);
    localparam int NS1 = (NSCRATCH > 0) ? NSCRATCH : 1;

    logic [7:0] r_div_sh, r_div_act;
    logic [3:0] r_vco_sh, r_vco_act;
    logic [5:0] r_lpf_sh, r_lpf_act;
    logic       r_en;
    logic       r_sync1, r_sync2, r_sync3;
    logic       r_lock_lost;
    logic [7:0] r_rdata;
    logic       r_rvalid, r_err, r_commit;

    logic       w_acc_wr, w_acc_rd, w_both;
    logic       w_sel_div, w_sel_vco, w_sel_lpf, w_sel_ctrl, w_sel_stat, w_sel_scr;
    logic       w_mapped, w_commit_req, w_commit_rej, w_commit_do;
    logic       w_pending, w_fall, w_err_next;
    logic [7:0] w_rd_val;
    logic [NS1-1:0] w_scr_hit;
    logic [7:0]     w_scr_q [NS1];

    // A simultaneous read and write is illegal and performs neither.
    assign w_both   = bus.wen & bus.ren;
    assign w_acc_wr = bus.wen & ~bus.ren;
    assign w_acc_rd = bus.ren & ~bus.wen;

    assign w_sel_div  = (bus.addr == AW'(0));
    assign w_sel_vco  = (bus.addr == AW'(1));
    assign w_sel_lpf  = (bus.addr == AW'(2));
    assign w_sel_ctrl = (bus.addr == AW'(3));
    assign w_sel_stat = (bus.addr == AW'(4));
    assign w_sel_scr  = |w_scr_hit;
    assign w_mapped   = w_sel_div | w_sel_vco | w_sel_lpf | w_sel_ctrl | w_sel_stat | w_sel_scr;

    assign w_commit_req = w_acc_wr & w_sel_ctrl & bus.wdata[1];
`ifdef PLL_REG_SAFE_COMMIT_EN
    // Decided on the enable value held before this write, not the one being written.
    assign w_commit_rej = w_commit_req & r_en;
`else
    assign w_commit_rej = 1'b0;
`endif
    assign w_commit_do = w_commit_req & ~w_commit_rej;

    assign w_pending  = (r_div_sh != r_div_act) | (r_vco_sh != r_vco_act) | (r_lpf_sh != r_lpf_act);
    assign w_fall     = r_sync3 & ~r_sync2;
    assign w_err_next = w_both | ((bus.wen | bus.ren) & ~w_mapped) | w_commit_rej;

    // Scratch registers, one per address from 0x05 upward.
    generate
        if (NSCRATCH > 0) begin : g_scr_on
            for (genvar gi = 0; gi < NSCRATCH; gi++) begin : g_scr
                logic [7:0] r_scr;
                assign w_scr_hit[gi] = (bus.addr == AW'(5 + gi));
                assign w_scr_q[gi]   = r_scr;
                // Scratch write on a legal write to this address.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        r_scr <= 8'h00;
                    else if (w_acc_wr & w_scr_hit[gi])
                        r_scr <= bus.wdata;
                end
            end
        end else begin : g_scr_off
            assign w_scr_hit  = 1'b0;
            assign w_scr_q[0] = 8'h00;
        end
    endgenerate

    // Read mux; unmapped addresses and write-only bits return 0.
    always_comb begin
        w_rd_val = 8'h00;
        if (w_sel_div)  w_rd_val = r_div_sh;
        if (w_sel_vco)  w_rd_val = {4'h0, r_vco_sh};
        if (w_sel_lpf)  w_rd_val = {2'b00, r_lpf_sh};
        if (w_sel_ctrl) w_rd_val = {7'h00, r_en};
        if (w_sel_stat) w_rd_val = {5'h00, w_pending, r_lock_lost, r_sync2};
        for (int i = 0; i < NS1; i++)
            if (w_scr_hit[i]) w_rd_val = w_scr_q[i];
    end

    // Shadow, active and control registers; commit copies shadow to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_sh  <= DIV_RST;
            r_vco_sh  <= VCO_RST;
            r_lpf_sh  <= LPF_RST;
            r_div_act <= DIV_RST;
            r_vco_act <= VCO_RST;
            r_lpf_act <= LPF_RST;
            r_en      <= 1'b0;
        end else begin
            if (w_acc_wr & w_sel_div)  r_div_sh <= bus.wdata;
            if (w_acc_wr & w_sel_vco)  r_vco_sh <= bus.wdata[3:0];
            if (w_acc_wr & w_sel_lpf)  r_lpf_sh <= bus.wdata[5:0];
            if (w_acc_wr & w_sel_ctrl) r_en     <= bus.wdata[0];
            if (w_commit_do) begin
                r_div_act <= r_div_sh;
                r_vco_act <= r_vco_sh;
                r_lpf_act <= r_lpf_sh;
            end
        end
    end

    // Lock synchroniser plus one delay stage for fall detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Sticky lock_lost; a set in the same cycle as a W1C clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lock_lost <= 1'b0;
        else if (w_fall & r_en)
            r_lock_lost <= 1'b1;
        else if (w_acc_wr & w_sel_stat & bus.wdata[1])
            r_lock_lost <= 1'b0;
    end

    // Registered read response, error and commit pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= 8'h00;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_commit <= 1'b0;
        end else begin
            r_rdata  <= w_acc_rd ? w_rd_val : 8'h00;
            r_rvalid <= w_acc_rd;
            r_err    <= w_err_next;
            r_commit <= w_commit_do;
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign bus.err    = r_err;
    assign div_cfg    = r_div_act;
    assign vco_gain   = r_vco_act;
    assign lpf_c2     = r_lpf_act[5:4];
    assign lpf_cp     = r_lpf_act[3:2];
    assign lpf_rp     = r_lpf_act[1:0];
    assign enable_pll = r_en;
    assign commit_o   = r_commit;
endmodule

// File: tb/tb_pll_reg_bank.sv
// Directed bench for pll_reg_bank: reads push expected data to a scoreboard
// queue, a negedge monitor pops and compares whenever rvalid is seen.
module tb_pll_reg_bank;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic [7:0] div_cfg;
    logic [3:0] vco_gain;
    logic [1:0] lpf_c2, lpf_cp, lpf_rp;
    logic       enable_pll, commit_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];

    pll_reg_bank_if #(.AW(8)) bus_if ();

    pll_reg_bank #(
        .AW(8), .NSCRATCH(2),
        .DIV_RST(8'h5A), .VCO_RST(4'h3), .LPF_RST(6'h15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if), .pll_locked(pll_locked),
        .div_cfg(div_cfg), .vco_gain(vco_gain), .lpf_c2(lpf_c2), .lpf_cp(lpf_cp),
        .lpf_rp(lpf_rp), .enable_pll(enable_pll), .commit_o(commit_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus_if.addr = a; bus_if.wdata = d; bus_if.wen = 1'b1;
        tick();
        bus_if.wen = 1'b0;
        $display("write addr=%02h data=%02h", a, d);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        bus_if.addr = a; bus_if.ren = 1'b1;
        exp_q.push_back(exp);
        tick();
        bus_if.ren = 1'b0;
    endtask

    // Scoreboard monitor: compare read data when rvalid, rdata must be 0 otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.rvalid) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_spurious", {31'd0, bus_if.rvalid}, 32'd0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("rdata", {24'd0, bus_if.rdata}, {24'd0, e});
                    $display("read  data=%02h expected=%02h", bus_if.rdata, e);
                end
            end else begin
                check("rdata_idle", {24'd0, bus_if.rdata}, 32'd0);
            end
        end
    end

    initial begin
        bus_if.addr = '0; bus_if.wdata = '0; bus_if.wen = 1'b0; bus_if.ren = 1'b0;
        repeat (3) tick();
        check("rst_div", {24'd0, div_cfg}, 32'h5A);
        check("rst_vco", {28'd0, vco_gain}, 32'h3);
        check("rst_lpf", {26'd0, lpf_c2, lpf_cp, lpf_rp}, 32'h15);
        check("rst_rvalid", {31'd0, bus_if.rvalid}, 32'd0);
        check("rst_commit", {31'd0, commit_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset values through the bus, back-to-back reads.
        rd(8'h00, 8'h5A); rd(8'h01, 8'h03); rd(8'h02, 8'h15);
        rd(8'h03, 8'h00); rd(8'h04, 8'h00);
        tick();

        // Shadow writes leave active outputs alone.
        wr(8'h00, 8'h3C); wr(8'h01, 8'hFF); wr(8'h02, 8'h2D);
        check("shadow_div_act", {24'd0, div_cfg}, 32'h5A);
        check("shadow_vco_act", {28'd0, vco_gain}, 32'h3);
        rd(8'h04, 8'h04);
        rd(8'h01, 8'h0F);
        tick();

        // Commit.
        wr(8'h03, 8'h02);
        check("commit_pulse", {31'd0, commit_o}, 32'd1);
        check("commit_div", {24'd0, div_cfg}, 32'h3C);
        check("commit_vco", {28'd0, vco_gain}, 32'hF);
        check("commit_c2", {30'd0, lpf_c2}, 32'd2);
        check("commit_cp", {30'd0, lpf_cp}, 32'd3);
        check("commit_rp", {30'd0, lpf_rp}, 32'd1);
        tick();
        check("commit_single", {31'd0, commit_o}, 32'd0);
        rd(8'h04, 8'h00);
        tick();

        // Lock loss with enable_pll set.
        wr(8'h03, 8'h01);
        check("enable_set", {31'd0, enable_pll}, 32'd1);
        pll_locked = 1'b1;
        repeat (4) tick();
        rd(8'h04, 8'h01);
        pll_locked = 1'b0;
        repeat (4) tick();
        rd(8'h04, 8'h02);
        wr(8'h04, 8'h02);
        rd(8'h04, 8'h00);
        pll_locked = 1'b1;
        repeat (4) tick();
        // Fall reaches the detector exactly on the W1C write edge.
        pll_locked = 1'b0;
        tick(); tick();
        wr(8'h04, 8'h02);
        rd(8'h04, 8'h02);
        tick();

        // Scratch and unmapped accesses.
        wr(8'h05, 8'hA5); wr(8'h06, 8'h5A);
        rd(8'h05, 8'hA5); rd(8'h06, 8'h5A);
        rd(8'h07, 8'h00);
        check("unmapped_rd_err", {31'd0, bus_if.err}, 32'd1);
        wr(8'h07, 8'hEE);
        check("unmapped_wr_err", {31'd0, bus_if.err}, 32'd1);
        tick();
        check("err_single", {31'd0, bus_if.err}, 32'd0);

        // wen and ren together.
        bus_if.addr = 8'h00; bus_if.wdata = 8'h99; bus_if.wen = 1'b1; bus_if.ren = 1'b1;
        tick();
        bus_if.wen = 1'b0; bus_if.ren = 1'b0;
        $display("write+read addr=00 data=99 (illegal)");
        check("both_err", {31'd0, bus_if.err}, 32'd1);
        check("both_rvalid", {31'd0, bus_if.rvalid}, 32'd0);
        rd(8'h00, 8'h3C);
        tick();

        // Commit while enabled.
        wr(8'h03, 8'h01);
        wr(8'h00, 8'h77);
        wr(8'h03, 8'h03);
`ifdef PLL_REG_SAFE_COMMIT_EN
        check("safe_div", {24'd0, div_cfg}, 32'h3C);
        check("safe_err", {31'd0, bus_if.err}, 32'd1);
        check("safe_commit", {31'd0, commit_o}, 32'd0);
`else
        check("en_commit_div", {24'd0, div_cfg}, 32'h77);
        check("en_commit_err", {31'd0, bus_if.err}, 32'd0);
        check("en_commit_pulse", {31'd0, commit_o}, 32'd1);
`endif
        tick();

        // Reset asserted during a commit write.
        wr(8'h00, 8'h11);
        bus_if.addr = 8'h03; bus_if.wdata = 8'h02; bus_if.wen = 1'b1;
        #3 rst_n = 1'b0;
        tick();
        bus_if.wen = 1'b0;
        $display("write addr=03 data=02 aborted by reset");
        check("rst_mid_div", {24'd0, div_cfg}, 32'h5A);
        check("rst_mid_lpf", {26'd0, lpf_c2, lpf_cp, lpf_rp}, 32'h15);
        check("rst_mid_en", {31'd0, enable_pll}, 32'd0);
        check("rst_mid_commit", {31'd0, commit_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_mid_no_pulse", {31'd0, commit_o}, 32'd0);
        check("rst_mid_div2", {24'd0, div_cfg}, 32'h5A);
        rd(8'h00, 8'h5A);
        rd(8'h05, 8'h00);
        repeat (2) tick();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
